md_issue_ctrl: RTL
==================

Name: md_issue_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide unit.
- Decodes the E-stage instruction and issues a one-cycle start pulse with the instruction word to the unit.
- Tracks the outstanding operation against the unit's busy flag and stalls the D stage on any HI/LO-class instruction until the unit is free.
- Includes a latency watchdog and an issued-operation counter.

Parameters:
- TIMEOUT, 32: cycles in BUSY without the unit going idle before the watchdog fires.
- CNT_W, 16: width of the issued-operation counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-low.
- instr_d  in  32  D-stage instruction word.
- instr_e  in  32  E-stage instruction word.
- valid_e  in  1  E-stage instruction is valid (not a bubble).
- flush  in  1  E stage is being squashed this cycle.
- md_busy  in  1  busy flag from the multiply/divide unit.
- md_start  out  1  start pulse to the unit.
- md_ir  out  32  instruction word driven to the unit (equals instr_e).
- stall_d  out  1  freeze PC and the D/E register, insert a bubble into E.
- md_pending  out  1  an operation has been issued and has not completed.
- md_timeout  out  1  sticky watchdog error flag.
- issue_cnt  out  CNT_W  number of mult/multu/div/divu ops issued, wrapping.

Behaviour:
- Instruction classes; all require opcode [31:26] = 0:
  - Op class, by funct [5:0]: mult 011000, multu 011001, div 011010, divu 011011.
  - Move class, by funct: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
  - md-class = op class or move class.
- States: IDLE, BUSY.
- Reset (reset==0 at a clock edge):
  - state = IDLE; watchdog counter = 0; md_timeout = 0; issue_cnt = 0.
  - md_start = 0 while reset is low, regardless of instr_e.
- md_start (combinational) = reset & state==IDLE & valid_e & !flush & instr_e is op class.
- md_ir = instr_e at all times; move-class ops reach the unit without a start pulse.
- IDLE:
  - If md_start, go to BUSY next edge, clear the watchdog, increment issue_cnt (wrap at 2^CNT_W).
  - Otherwise stay in IDLE.
- BUSY:
  - First cycle is a grace cycle: stay in BUSY regardless of md_busy, because the unit raises busy at the same edge it samples start.
  - From the second cycle on: if md_busy==0, go to IDLE next edge.
  - Watchdog increments each BUSY cycle. On reaching TIMEOUT-1 while md_busy is still 1: set md_timeout, go to IDLE.
  - md_timeout stays set until reset.
- md_pending = (state==BUSY).
- stall_d (combinational) = instr_d is md-class & (state==BUSY | md_start).
  - Non-md instructions in D never stall.
  - An md-class op never reaches E while BUSY, so a second start cannot be issued while one is outstanding.
- Flush:
  - Flush in the same cycle as a would-be start suppresses the start; state and counter are unchanged.
  - Flush during BUSY does not abort; the unit cannot be cancelled. State tracks md_busy normally.
- Reset mid-operation: state goes to IDLE immediately. The unit is reset by the same signal.
- End-to-end latency: a mult in E at cycle N gives md_start in N. An mflo in D is held and reaches E at the first cycle after the controller returns to IDLE.

Optional Feature:
- MD_STALL_CNT_EN defined:
  - Adds output stall_cnt [31:0], incremented on every cycle with stall_d==1, wrapping at 2^32, cleared by reset.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with instr_e=mult (0x00850018) and valid_e=1 -> md_start=0, issue_cnt=0, md_timeout=0, state IDLE.
- Single mult: instr_e=0x00850018, valid_e=1; the unit model holds busy for 5 cycles -> md_start high for exactly 1 cycle, md_pending high for 6 cycles, issue_cnt=1.
- Back-to-back: div (0x0085001A) in E with mflo (0x00001012) in D -> stall_d=1 from the start cycle until the cycle after the first cycle with md_busy==0; add (0x00851020) in D gives stall_d=0.
- Flush: flush=1 in the same cycle as a multu in E -> md_start=0, state stays IDLE, issue_cnt unchanged.
- Watchdog: TIMEOUT=8 and the model holds md_busy=1 forever -> md_timeout=1 after 8 BUSY cycles, then IDLE; the flag survives the next op and clears only on reset.
- Wrap: CNT_W=4, issue 17 mult ops -> issue_cnt=1; with MD_STALL_CNT_EN, stall_cnt equals the number of stalled cycles counted by the bench.

Source files
------------

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : md_issue_ctrl                                            |
// | Description : Pipeline-side initiator for the multiply/divide unit.    |
// |               Issues a one-cycle start for mult/multu/div/divu in E,   |
// |               tracks the outstanding op against md_busy, stalls D on   |
// |               HI/LO-class instructions, and runs a latency watchdog    |
// |               and an issued-operation counter.                         |
// | Options     : define MD_STALL_CNT_EN to add the 32-bit stall_cnt port. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module md_issue_ctrl #(
  parameter int TIMEOUT = 32,  // must be >= 2: watchdog count 0 marks the grace cycle
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  input  logic [31:0]      instr_e,
  input  logic             valid_e,
  input  logic             flush,
  input  logic             md_busy,
  output logic             md_start,
  output logic [31:0]      md_ir,
  output logic             stall_d,
  output logic             md_pending,
  output logic             md_timeout,
  output logic [CNT_W-1:0] issue_cnt
`ifdef MD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  // Watchdog only has to count up to TIMEOUT-1 before it either fires or the unit goes idle.
  localparam int                c_WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  // Opcode field and funct groups: op class is funct 0110xx, move class is 0100xx.
  localparam logic [5:0] c_OPC_SPECIAL = 6'b000000;
  localparam logic [3:0] c_FN_OP_GRP   = 4'b0110;
  localparam logic [3:0] c_FN_MOVE_GRP = 4'b0100;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_WD_W-1:0]  r_wd;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_issue_cnt;

  logic w_op_e;
  logic w_md_d;
  logic w_start;
  logic w_unused_d;

  // mult/multu/div/divu
  function automatic logic f_is_op(input logic [31:0] w);
    return (w[31:26] == c_OPC_SPECIAL) && (w[5:2] == c_FN_OP_GRP);
  endfunction

  // mfhi/mthi/mflo/mtlo
  function automatic logic f_is_move(input logic [31:0] w);
    return (w[31:26] == c_OPC_SPECIAL) && (w[5:2] == c_FN_MOVE_GRP);
  endfunction

  assign w_op_e  = f_is_op(instr_e);
  assign w_md_d  = f_is_op(instr_d) | f_is_move(instr_d);

  // Register fields of the D-stage word play no part in the decode.
  assign w_unused_d = &{1'b0, instr_d[25:6]};

  // Start is gated by reset so the unit never sees a pulse while both are held in reset.
  assign w_start = reset & (r_state == S_IDLE) & valid_e & ~flush & w_op_e;

  assign md_start   = w_start;
  assign md_ir      = instr_e;
  assign md_pending = (r_state == S_BUSY);
  assign md_timeout = r_timeout;
  assign issue_cnt  = r_issue_cnt;

  // A HI/LO-class instruction in D waits while an op is outstanding or being issued this cycle.
  assign stall_d = w_md_d & ((r_state == S_BUSY) | w_start);

  // Issue/complete tracking, watchdog, sticky timeout flag and issued-op counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wd        <= '0;
      r_timeout   <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_BUSY;
            r_wd        <= '0;
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
        end
        S_BUSY: begin
          r_wd <= r_wd + 1'b1;
          // Watchdog at zero is the grace cycle: the unit only raises busy at the start edge.
          if (r_wd != '0) begin
            if (!md_busy) begin
              r_state <= S_IDLE;
            end else if (r_wd == c_WD_LAST) begin
              r_timeout <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Free-running count of D-stage stall cycles, wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (stall_d) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
